// File: rtl/axi_arb_pkg.sv
// Shared types and helpers for the AXI-light round-robin arbiter.
package axi_arb_pkg;

    // Arbiter FSM states
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR      = 3'd1,
        WR_RESP = 3'd2,
        RD      = 3'd3,
        RD_RESP = 3'd4
    } state_t;

    localparam int DEF_NUM_MASTERS = 4;
    localparam int DEF_ADDR_WIDTH  = 32;
    localparam int DEF_DATA_WIDTH  = 32;

    // Index width for n requesters; never narrower than one bit
    function automatic int id_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/axi_light_rr_pick.sv
// Combinational round-robin picker: first set request at or above the
// pointer, wrapping from NUM_MASTERS-1 back to 0.
module axi_light_rr_pick
    import axi_arb_pkg::*;
#(
    parameter int NUM_MASTERS = DEF_NUM_MASTERS,
    localparam int ID_W = id_width(NUM_MASTERS)
) (
    input  logic [NUM_MASTERS-1:0] i_req,
    input  logic [ID_W-1:0]        i_rr_ptr,
    output logic [ID_W-1:0]        o_winner,
    output logic                   o_found
);

    // Doubling the request vector turns the wrapped scan into a plain shift
    logic [2*NUM_MASTERS-1:0] w_req2;
    logic [2*NUM_MASTERS-1:0] w_rot;
    logic [ID_W:0]            w_pos;
    logic [ID_W:0]            w_sum;

    assign w_req2 = {i_req, i_req};
    assign w_rot  = w_req2 >> i_rr_ptr;

    // Lowest set bit of the rotated vector is the nearest requester
    always_comb begin
        w_pos   = '0;
        o_found = 1'b0;
        for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_pos   = (ID_W + 1)'(i);
                o_found = 1'b1;
            end
        end
    end

    // Map the offset back to an absolute index, modulo NUM_MASTERS
    always_comb begin
        w_sum = {1'b0, i_rr_ptr} + w_pos;
        if (w_sum >= (ID_W + 1)'(NUM_MASTERS)) begin
            w_sum = w_sum - (ID_W + 1)'(NUM_MASTERS);
        end
        o_winner = w_sum[ID_W-1:0];
    end

endmodule

// File: rtl/axi_light_rr_arbiter.sv
// Round-robin arbiter sharing one AXI-light slave port among NUM_MASTERS
// masters, one transaction in flight. Optional per-master response
// counters are built when AXI_ARB_PERF_EN is defined.
//
// Handshake rule: a transfer on any channel happens on a rising clk edge
// where both valid and ready are high; a granted master's valid is routed
// to the shared side and the shared ready back to that master only.
module axi_light_rr_arbiter
    import axi_arb_pkg::*;
#(
    parameter int NUM_MASTERS = DEF_NUM_MASTERS,
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    localparam int ID_W   = id_width(NUM_MASTERS),
    localparam int STRB_W = DATA_WIDTH / 8
) (
    input  logic                              clk,
    input  logic                              res_n,
    // per-master side
    input  logic [NUM_MASTERS-1:0]            s_aw_valid,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] s_aw_addr,
    output logic [NUM_MASTERS-1:0]            s_aw_ready,
    input  logic [NUM_MASTERS-1:0]            s_w_valid,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0] s_w_data,
    input  logic [NUM_MASTERS*STRB_W-1:0]     s_w_strb,
    output logic [NUM_MASTERS-1:0]            s_w_ready,
    output logic [NUM_MASTERS-1:0]            s_b_valid,
    input  logic [NUM_MASTERS-1:0]            s_b_ready,
    input  logic [NUM_MASTERS-1:0]            s_ar_valid,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] s_ar_addr,
    output logic [NUM_MASTERS-1:0]            s_ar_ready,
    output logic [NUM_MASTERS-1:0]            s_r_valid,
    output logic [NUM_MASTERS*DATA_WIDTH-1:0] s_r_data,
    input  logic [NUM_MASTERS-1:0]            s_r_ready,
    // shared slave side
    output logic                              m_aw_valid,
    output logic [ADDR_WIDTH-1:0]             m_aw_addr,
    input  logic                              m_aw_ready,
    output logic                              m_w_valid,
    output logic [DATA_WIDTH-1:0]             m_w_data,
    output logic [STRB_W-1:0]                 m_w_strb,
    input  logic                              m_w_ready,
    input  logic                              m_b_valid,
    output logic                              m_b_ready,
    output logic                              m_ar_valid,
    output logic [ADDR_WIDTH-1:0]             m_ar_addr,
    input  logic                              m_ar_ready,
    input  logic                              m_r_valid,
    input  logic [DATA_WIDTH-1:0]             m_r_data,
    output logic                              m_r_ready,
    // status and debug
    output logic [ID_W-1:0]                   grant_id,
    output logic                              busy,
    output state_t                            dbg_state,
    output logic [ID_W-1:0]                   dbg_rr_ptr
`ifdef AXI_ARB_PERF_EN
    ,
    output logic [NUM_MASTERS*32-1:0]         grant_cnt
`endif
);

    state_t                 r_state;
    logic [ID_W-1:0]        r_grant_id;
    logic [ID_W-1:0]        r_rr_ptr;
    logic                   r_busy;
    logic                   r_aw_done;
    logic                   r_w_done;

    logic [NUM_MASTERS-1:0] w_wr_req;
    logic [NUM_MASTERS-1:0] w_req;
    logic [ID_W-1:0]        w_winner;
    logic                   w_found;
    logic [ID_W-1:0]        w_next_ptr;

    logic                   w_g_aw_valid;
    logic                   w_g_w_valid;
    logic                   w_g_b_ready;
    logic                   w_g_ar_valid;
    logic                   w_g_r_ready;
    logic                   w_aw_hs;
    logic                   w_w_hs;
    logic                   w_b_hs;
    logic                   w_ar_hs;
    logic                   w_r_hs;

    assign w_wr_req = s_aw_valid & s_w_valid;
    assign w_req    = w_wr_req | s_ar_valid;

    axi_light_rr_pick #(
        .NUM_MASTERS (NUM_MASTERS)
    ) u_pick (
        .i_req    (w_req),
        .i_rr_ptr (r_rr_ptr),
        .o_winner (w_winner),
        .o_found  (w_found)
    );

    // Controls from the granted master only
    assign w_g_aw_valid = s_aw_valid[r_grant_id];
    assign w_g_w_valid  = s_w_valid[r_grant_id];
    assign w_g_b_ready  = s_b_ready[r_grant_id];
    assign w_g_ar_valid = s_ar_valid[r_grant_id];
    assign w_g_r_ready  = s_r_ready[r_grant_id];

    assign w_aw_hs = (r_state == WR) && w_g_aw_valid && !r_aw_done && m_aw_ready;
    assign w_w_hs  = (r_state == WR) && w_g_w_valid && !r_w_done && m_w_ready;
    assign w_b_hs  = (r_state == WR_RESP) && m_b_valid && w_g_b_ready;
    assign w_ar_hs = (r_state == RD) && w_g_ar_valid && m_ar_ready;
    assign w_r_hs  = (r_state == RD_RESP) && m_r_valid && w_g_r_ready;

    assign w_next_ptr = (r_grant_id == ID_W'(NUM_MASTERS - 1)) ? '0 : r_grant_id + 1'b1;

    assign grant_id   = r_grant_id;
    assign busy       = r_busy;
    assign dbg_state  = r_state;
    assign dbg_rr_ptr = r_rr_ptr;

    // Channel routing: only the locked master sees anything, and only in
    // the phase that owns the channel
    always_comb begin
        m_aw_valid = 1'b0;
        m_aw_addr  = '0;
        m_w_valid  = 1'b0;
        m_w_data   = '0;
        m_w_strb   = '0;
        m_b_ready  = 1'b0;
        m_ar_valid = 1'b0;
        m_ar_addr  = '0;
        m_r_ready  = 1'b0;
        s_aw_ready = '0;
        s_w_ready  = '0;
        s_b_valid  = '0;
        s_ar_ready = '0;
        s_r_valid  = '0;
        s_r_data   = '0;
        case (r_state)
            WR: begin
                m_aw_valid             = w_g_aw_valid && !r_aw_done;
                m_aw_addr              = s_aw_addr[r_grant_id*ADDR_WIDTH +: ADDR_WIDTH];
                m_w_valid              = w_g_w_valid && !r_w_done;
                m_w_data               = s_w_data[r_grant_id*DATA_WIDTH +: DATA_WIDTH];
                m_w_strb               = s_w_strb[r_grant_id*STRB_W +: STRB_W];
                s_aw_ready[r_grant_id] = m_aw_ready && !r_aw_done;
                s_w_ready[r_grant_id]  = m_w_ready && !r_w_done;
            end
            WR_RESP: begin
                s_b_valid[r_grant_id] = m_b_valid;
                m_b_ready             = w_g_b_ready;
            end
            RD: begin
                m_ar_valid             = w_g_ar_valid;
                m_ar_addr              = s_ar_addr[r_grant_id*ADDR_WIDTH +: ADDR_WIDTH];
                s_ar_ready[r_grant_id] = m_ar_ready;
            end
            RD_RESP: begin
                s_r_valid[r_grant_id]                          = m_r_valid;
                s_r_data[r_grant_id*DATA_WIDTH +: DATA_WIDTH]  = m_r_data;
                m_r_ready                                      = w_g_r_ready;
            end
            default: begin
            end
        endcase
    end

    // Grant FSM: lock a master in IDLE, release it on its response handshake
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            r_state    <= IDLE;
            r_grant_id <= '0;
            r_rr_ptr   <= '0;
            r_busy     <= 1'b0;
            r_aw_done  <= 1'b0;
            r_w_done   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_grant_id <= w_winner;
                        r_busy     <= 1'b1;
                        r_state    <= w_wr_req[w_winner] ? WR : RD;
                    end
                end
                WR: begin
                    if (w_aw_hs) r_aw_done <= 1'b1;
                    if (w_w_hs)  r_w_done  <= 1'b1;
                    if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) begin
                        r_state <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (w_b_hs) begin
                        r_aw_done <= 1'b0;
                        r_w_done  <= 1'b0;
                        r_rr_ptr  <= w_next_ptr;
                        r_busy    <= 1'b0;
                        r_state   <= IDLE;
                    end
                end
                RD: begin
                    if (w_ar_hs) r_state <= RD_RESP;
                end
                RD_RESP: begin
                    if (w_r_hs) begin
                        r_rr_ptr <= w_next_ptr;
                        r_busy   <= 1'b0;
                        r_state  <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

`ifdef AXI_ARB_PERF_EN
    logic [NUM_MASTERS*32-1:0] r_grant_cnt;

    assign grant_cnt = r_grant_cnt;

    // Count completed transactions per master (wrapping)
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            r_grant_cnt <= '0;
        end else if (w_b_hs || w_r_hs) begin
            r_grant_cnt[r_grant_id*32 +: 32] <= r_grant_cnt[r_grant_id*32 +: 32] + 32'd1;
        end
    end
`endif

endmodule
